// File: rtl/chunked_addsub_if.sv
// chunked_addsub_if
//   Handshake and data bundle for the chunked add/subtract unit.
//   master: requester (drives start/op/sat_en/a/b, observes results)
//   slave : the unit itself
//   start   request, sampled only while busy is low
//   op      0 = a+b, 1 = a-b
//   sat_en  saturate the result on signed overflow
//   a, b    two's complement operands
//   busy    slices are being processed
//   done    one-cycle pulse, out/carry/ovf valid in the same cycle
//   out     result, held until the next done
//   carry   carry out of the MSB (subtract: 1 = no borrow)
//   ovf     signed overflow of the unsaturated result
interface chunked_addsub_if #(
   parameter int unsigned WIDTH = 32
);
   logic             start;
   logic             op;
   logic             sat_en;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] out;
   logic             carry;
   logic             ovf;

   modport master (
      output start, op, sat_en, a, b,
      input  busy, done, out, carry, ovf
   );

   modport slave (
      input  start, op, sat_en, a, b,
      output busy, done, out, carry, ovf
   );
endinterface

// File: rtl/chunked_addsub.sv
// chunked_addsub
//   Multi-cycle add/subtract for the MDR datapath. The operands are processed
//   CHUNK bits per cycle, LSB slice first, with the carry/borrow kept in a
//   register between slices, so no carry chain is longer than CHUNK bits.
//   Provides operation select, optional signed saturation, carry and
//   overflow flags and a start/busy/done handshake.
//   clk  rising-edge clock
//   rst  synchronous reset, active-high (aborts any operation in progress)
//   bus  chunked_addsub_if.slave: start/op/sat_en/a/b in,
//        busy/done/out/carry/ovf out
module chunked_addsub #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CHUNK = 8
) (
   input  logic            clk,
   input  logic            rst,
   chunked_addsub_if.slave bus
);
   localparam int unsigned N  = WIDTH / CHUNK;
   localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(N - 1);
   localparam logic [WIDTH-1:0] MIN_VAL = WIDTH'(1) << (WIDTH - 1);
   localparam logic [WIDTH-1:0] MAX_VAL = ~MIN_VAL;

   generate
      if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
         $error("chunked_addsub: WIDTH must be a multiple of CHUNK");
      end
   endgenerate

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;          // b_eff: ~b for subtract
   logic             a_msb_q, a_msb_d;
   logic             b_msb_q, b_msb_d;
   logic             sat_q, sat_d;
   logic             c_q, c_d;
   logic [KW-1:0]    k_q, k_d;
   logic [WIDTH-1:0] part_q, part_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             carry_q, carry_d;
   logic             ovf_q, ovf_d;
   logic             done_q, done_d;

   logic [CHUNK:0]   slice_sum;
   logic [WIDTH-1:0] b_eff;
   logic             ovf_w;

   // Operands are shifted down one slice per cycle so the current slice is
   // always at the bottom; the result is shifted in from the top, so after
   // N slices part holds the full result in its natural position.
   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      a_msb_d   = a_msb_q;
      b_msb_d   = b_msb_q;
      sat_d     = sat_q;
      c_d       = c_q;
      k_d       = k_q;
      part_d    = part_q;
      out_d     = out_q;
      carry_d   = carry_q;
      ovf_d     = ovf_q;
      done_d    = 1'b0;
      ovf_w     = 1'b0;
      b_eff     = bus.op ? ~bus.b : bus.b;
      slice_sum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]}
                  + {{CHUNK{1'b0}}, c_q};

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               a_d     = bus.a;
               b_d     = b_eff;
               a_msb_d = bus.a[WIDTH-1];
               b_msb_d = b_eff[WIDTH-1];
               sat_d   = bus.sat_en;
               c_d     = bus.op;
               k_d     = '0;
               part_d  = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            c_d    = slice_sum[CHUNK];
            a_d    = a_q >> CHUNK;
            b_d    = b_q >> CHUNK;
            part_d = (part_q >> CHUNK)
                     | (WIDTH'(slice_sum[CHUNK-1:0]) << (WIDTH - CHUNK));
            k_d    = k_q + KW'(1);
            if (k_q == K_LAST) begin
               ovf_w   = (a_msb_q == b_msb_q) && (part_d[WIDTH-1] != a_msb_q);
               ovf_d   = ovf_w;
               carry_d = slice_sum[CHUNK];
               out_d   = (sat_q && ovf_w) ? (a_msb_q ? MIN_VAL : MAX_VAL)
                                          : part_d;
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         a_msb_q <= 1'b0;
         b_msb_q <= 1'b0;
         sat_q   <= 1'b0;
         c_q     <= 1'b0;
         k_q     <= '0;
         part_q  <= '0;
         out_q   <= '0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         a_msb_q <= a_msb_d;
         b_msb_q <= b_msb_d;
         sat_q   <= sat_d;
         c_q     <= c_d;
         k_q     <= k_d;
         part_q  <= part_d;
         out_q   <= out_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
         done_q  <= done_d;
      end
   end

   assign bus.busy  = (state_q == RUN);
   assign bus.done  = done_q;
   assign bus.out   = out_q;
   assign bus.carry = carry_q;
   assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_chunked_addsub.sv
// tb_chunked_addsub
//   Directed vectors for chunked_addsub (WIDTH=32, CHUNK=8). Expected results
//   are queued when a request is issued; a monitor pops them on each done.
module tb_chunked_addsub;
   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   chunked_addsub_if #(.WIDTH(32)) bus ();

   chunked_addsub #(.WIDTH(32), .CHUNK(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [31:0] out;
      logic        carry;
      logic        ovf;
   } exp_t;

   exp_t sb[$];
   int   passed = 0;
   int   total  = 0;
   int   done_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   // Monitor: every done pulse is matched against the oldest expectation.
   always @(negedge clk) begin
      if (bus.done === 1'b1) begin
         exp_t e;
         done_cnt++;
         if (sb.size() == 0) begin
            total++;
            $display("FAIL unexpected_done: got done with out=0x%08h, expected no done",
                     bus.out);
         end else begin
            e = sb.pop_front();
            chk("out",   bus.out,          e.out);
            chk("carry", 32'(bus.carry),   32'(e.carry));
            chk("ovf",   32'(bus.ovf),     32'(e.ovf));
         end
      end
   end

   // Issues one request at the current post-edge point and returns in the
   // done cycle (or after a timeout). Checks latency and busy length.
   task automatic do_op(input logic o, input logic s,
                        input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] ex_out, input logic ex_c,
                        input logic ex_v, input logic poke);
      int edges;
      int busy_cnt;
      sb.push_back('{out: ex_out, carry: ex_c, ovf: ex_v});
      bus.start  = 1'b1;
      bus.op     = o;
      bus.sat_en = s;
      bus.a      = av;
      bus.b      = bv;
      @(posedge clk); #1;
      bus.start  = 1'b0;
      bus.op     = ~o;
      bus.sat_en = ~s;
      bus.a      = ~av;
      bus.b      = ~bv;
      edges      = 1;
      busy_cnt   = 0;
      while (bus.done !== 1'b1 && edges < 20) begin
         if (bus.busy === 1'b1) busy_cnt++;
         bus.start = (poke && edges == 2);
         if (poke && edges == 2) begin
            bus.op = 1'b0; bus.sat_en = 1'b0; bus.a = 32'd1; bus.b = 32'd1;
         end
         @(posedge clk); #1;
         edges++;
      end
      bus.start = 1'b0;
      chk("latency_edges", 32'(edges), 32'd5);
      chk("busy_cycles", 32'(busy_cnt), 32'd4);
      chk("busy_low_in_done", 32'(bus.busy), 32'd0);
   endtask

   initial begin
      int d0;
      rst        = 1'b1;
      bus.start  = 1'b0;
      bus.op     = 1'b0;
      bus.sat_en = 1'b0;
      bus.a      = '0;
      bus.b      = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy",  32'(bus.busy),  32'd0);
      chk("rst_done",  32'(bus.done),  32'd0);
      chk("rst_out",   bus.out,        32'd0);
      chk("rst_carry", 32'(bus.carry), 32'd0);
      chk("rst_ovf",   32'(bus.ovf),   32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // op sat a b -> out carry ovf
      do_op(1'b1, 1'b0, 32'd5,        32'd3,        32'h00000002, 1'b1, 1'b0, 1'b0);
      do_op(1'b1, 1'b0, 32'd3,        32'd5,        32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
      do_op(1'b0, 1'b0, 32'h000000FF, 32'h00000001, 32'h00000100, 1'b0, 1'b0, 1'b0);
      do_op(1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0);
      do_op(1'b0, 1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0);
      do_op(1'b0, 1'b1, 32'h7FFFFFFF, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0);
      do_op(1'b0, 1'b1, 32'h80000000, 32'h80000000, 32'h80000000, 1'b1, 1'b1, 1'b0);

      // Ignored start mid-operation, then a back-to-back start in the done cycle.
      @(posedge clk); #1;
      d0 = done_cnt;
      do_op(1'b1, 1'b1, 32'h80000000, 32'h00000001, 32'h80000000, 1'b1, 1'b1, 1'b1);
      do_op(1'b0, 1'b0, 32'h12345678, 32'h11111111, 32'h23456789, 1'b0, 1'b0, 1'b0);
      repeat (8) begin @(posedge clk); #1; end
      chk("done_pulses", 32'(done_cnt - d0), 32'd2);
      chk("out_held", bus.out, 32'h23456789);

      // Reset during the second RUN cycle aborts with no done.
      bus.start = 1'b1; bus.op = 1'b1; bus.sat_en = 1'b0;
      bus.a = 32'd9; bus.b = 32'd4;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_busy",  32'(bus.busy),  32'd0);
      chk("abort_done",  32'(bus.done),  32'd0);
      chk("abort_out",   bus.out,        32'd0);
      chk("abort_carry", 32'(bus.carry), 32'd0);
      chk("abort_ovf",   32'(bus.ovf),   32'd0);
      d0 = done_cnt;
      repeat (10) begin @(posedge clk); #1; end
      chk("no_done_after_abort", 32'(done_cnt - d0), 32'd0);
      chk("idle_after_abort", 32'(bus.busy), 32'd0);

      // Recovery after the abort.
      do_op(1'b1, 1'b0, 32'd5, 32'd3, 32'h00000002, 1'b1, 1'b0, 1'b0);
      repeat (3) begin @(posedge clk); #1; end
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
